// File: rtl/ctnr_reload_if.sv
// Bus bundle for the loadable up/down counter with reload register.
// The master drives control and load data; the slave (the counter) returns
// its count, the inverted count, the cascade carry and its status flags.
interface ctnr_reload_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] D;
    logic             LD;
    logic             LDR;
    logic             ENAB;
    logic             UP;
    logic [1:0]       MODE;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] QL;
    logic             CO;
    logic             TC;
    logic             RUN;

    modport master (
        output D, LD, LDR, ENAB, UP, MODE,
        input  Q, QL, CO, TC, RUN
    );

    modport slave (
        input  D, LD, LDR, ENAB, UP, MODE,
        output Q, QL, CO, TC, RUN
    );
endinterface

// File: rtl/ctnr_reload.sv
// Cascadable up/down counter with reload register.
// Modes: free-run wrap, periodic reload, one-shot (stops after reload), hold.
// Q, TC and RUN are registered; CO is combinational so a higher stage can
// use it as its count enable in the same cycle.
module ctnr_reload #(
    parameter int WIDTH = 16
) (
    input  logic          CK,
    input  logic          RESET,
    ctnr_reload_if.slave  bus
);
    localparam logic [1:0] MODE_FREE = 2'b00;
    localparam logic [1:0] MODE_PER  = 2'b01;
    localparam logic [1:0] MODE_ONE  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             run_q, run_d;
    logic             tc_q, tc_d;

    logic [WIDTH-1:0] tv;
    logic             at_tv;
    logic             step;

    // Terminal value follows the current direction; a step is allowed only
    // when enabled, running, not in hold and not being overridden by a load.
    always_comb begin
        tv    = bus.UP ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        at_tv = (q_q == tv);
        step  = bus.ENAB & run_q & (bus.MODE != MODE_HOLD) & ~bus.LD;
    end

    // Next-state: load has priority over counting; reload register is
    // written independently of the counter load.
    always_comb begin
        q_d   = q_q;
        rld_d = rld_q;
        run_d = run_q;
        tc_d  = 1'b0;

        if (bus.LDR) begin
            rld_d = bus.D;
        end

        if (bus.LD) begin
            q_d   = bus.D;
            run_d = 1'b1;
        end else begin
            // Leaving one-shot mode (or never being in it) re-arms the counter.
            if (bus.MODE != MODE_ONE) begin
                run_d = 1'b1;
            end
            if (step) begin
                if (at_tv) begin
                    tc_d = 1'b1;
                    case (bus.MODE)
                        MODE_PER: q_d = rld_q;
                        MODE_ONE: begin
                            q_d   = rld_q;
                            run_d = 1'b0;
                        end
                        // Free-run: plain modulo step gives the wrap.
                        default:  q_d = bus.UP ? q_q + 1'b1 : q_q - 1'b1;
                    endcase
                end else begin
                    q_d = bus.UP ? q_q + 1'b1 : q_q - 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset overriding every strobe.
    always_ff @(posedge CK) begin
        if (RESET) begin
            q_q   <= '0;
            rld_q <= '0;
            run_q <= 1'b1;
            tc_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            rld_q <= rld_d;
            run_q <= run_d;
            tc_q  <= tc_d;
        end
    end

    assign bus.Q   = q_q;
    assign bus.QL  = ~q_q;
    assign bus.TC  = tc_q;
    assign bus.RUN = run_q;
    assign bus.CO  = step & at_tv;

endmodule

// File: tb/tb_ctnr_reload.sv
// Bench for ctnr_reload: an 8-bit instance driven through a table of
// transactions with a scoreboard queue, plus a 4-bit two-stage cascade.
module tb_ctnr_reload;
    logic CK;
    logic rst_8;
    logic rst_c;

    ctnr_reload_if #(.WIDTH(8)) bus8 ();
    ctnr_reload_if #(.WIDTH(4)) lo_if ();
    ctnr_reload_if #(.WIDTH(4)) hi_if ();

    ctnr_reload #(.WIDTH(8)) dut8 (.CK(CK), .RESET(rst_8), .bus(bus8.slave));
    ctnr_reload #(.WIDTH(4)) dut_lo (.CK(CK), .RESET(rst_c), .bus(lo_if.slave));
    ctnr_reload #(.WIDTH(4)) dut_hi (.CK(CK), .RESET(rst_c), .bus(hi_if.slave));

    // Upper stage counts on the lower stage's carry.
    assign hi_if.ENAB = lo_if.CO;

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       tc;
        logic       run;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: pops the expectation pushed for this edge and compares outputs.
    always @(posedge CK) begin
        if (sb.size() != 0) begin
            #1;
            mon_e = sb.pop_front();
            check({mon_e.tag, ".q"},   {24'd0, bus8.Q},  {24'd0, mon_e.q});
            check({mon_e.tag, ".ql"},  {24'd0, bus8.QL}, {24'd0, ~mon_e.q});
            check({mon_e.tag, ".tc"},  {31'd0, bus8.TC}, {31'd0, mon_e.tc});
            check({mon_e.tag, ".run"}, {31'd0, bus8.RUN}, {31'd0, mon_e.run});
            $display("txn %-8s Q=%02h TC=%0d RUN=%0d", mon_e.tag, bus8.Q, bus8.TC, bus8.RUN);
        end
    end

    // One transaction: drive inputs, check combinational CO, queue the
    // expected registered state after the next edge.
    task automatic cyc(input string tag, input logic rst, input logic ld, input logic ldr,
                       input logic en, input logic up, input logic [1:0] mode,
                       input logic [7:0] d, input logic [7:0] eq, input logic etc,
                       input logic erun, input logic eco);
        exp_t e;
        rst_8     = rst;
        bus8.LD   = ld;
        bus8.LDR  = ldr;
        bus8.ENAB = en;
        bus8.UP   = up;
        bus8.MODE = mode;
        bus8.D    = d;
        #1;
        if (eco !== 1'bx) begin
            check({tag, ".co"}, {31'd0, bus8.CO}, {31'd0, eco});
        end
        e.tag = tag;
        e.q   = eq;
        e.tc  = etc;
        e.run = erun;
        sb.push_back(e);
        @(posedge CK);
        #2;
    endtask

    task automatic cas_check(input string tag, input logic [3:0] lo_q, input logic [3:0] hi_q,
                             input logic lo_tc, input logic run);
        check({tag, ".lo_q"},  {28'd0, lo_if.Q},   {28'd0, lo_q});
        check({tag, ".hi_q"},  {28'd0, hi_if.Q},   {28'd0, hi_q});
        check({tag, ".lo_tc"}, {31'd0, lo_if.TC},  {31'd0, lo_tc});
        check({tag, ".hi_tc"}, {31'd0, hi_if.TC},  1'b0);
        check({tag, ".run"},   {31'd0, lo_if.RUN & hi_if.RUN}, {31'd0, run});
        $display("txn %-8s lo=%0h hi=%0h loTC=%0d", tag, lo_if.Q, hi_if.Q, lo_if.TC);
    endtask

    initial begin
        rst_c = 1'b1;
        lo_if.D = 4'h0; lo_if.LD = 1'b0; lo_if.LDR = 1'b0; lo_if.ENAB = 1'b0;
        lo_if.UP = 1'b1; lo_if.MODE = 2'b00;
        hi_if.D = 4'h0; hi_if.LD = 1'b0; hi_if.LDR = 1'b0;
        hi_if.UP = 1'b1; hi_if.MODE = 2'b00;

        //   tag        rst ld ldr en up mode  d      Q    TC RUN CO
        cyc("rst0",     1, 0, 0, 0, 1, 2'd0, 8'h00, 8'h00, 0, 1, 1'bx);
        cyc("rst1",     1, 1, 1, 1, 1, 2'd0, 8'hAA, 8'h00, 0, 1, 0);
        // Free-run up through the wrap
        cyc("fr_ld",    0, 1, 0, 0, 1, 2'd0, 8'hFE, 8'hFE, 0, 1, 0);
        cyc("fr_1",     0, 0, 0, 1, 1, 2'd0, 8'h00, 8'hFF, 0, 1, 0);
        cyc("fr_2",     0, 0, 0, 1, 1, 2'd0, 8'h00, 8'h00, 1, 1, 1);
        cyc("fr_3",     0, 0, 0, 1, 1, 2'd0, 8'h00, 8'h01, 0, 1, 0);
        // Direction change takes effect immediately; down wrap then up wrap
        cyc("dn_1",     0, 0, 0, 1, 0, 2'd0, 8'h00, 8'h00, 0, 1, 0);
        cyc("dn_wrap",  0, 0, 0, 1, 0, 2'd0, 8'h00, 8'hFF, 1, 1, 1);
        cyc("up_wrap",  0, 0, 0, 1, 1, 2'd0, 8'h00, 8'h00, 1, 1, 1);
        // Periodic reload, counting down
        cyc("pr_ldr",   0, 0, 1, 0, 0, 2'd1, 8'h03, 8'h00, 0, 1, 0);
        cyc("pr_ld",    0, 1, 0, 1, 0, 2'd1, 8'h01, 8'h01, 0, 1, 0);
        cyc("pr_a",     0, 0, 0, 1, 0, 2'd1, 8'h00, 8'h00, 0, 1, 0);
        cyc("pr_b",     0, 0, 0, 1, 0, 2'd1, 8'h00, 8'h03, 1, 1, 1);
        cyc("pr_c",     0, 0, 0, 1, 0, 2'd1, 8'h00, 8'h02, 0, 1, 0);
        cyc("pr_d",     0, 0, 0, 1, 0, 2'd1, 8'h00, 8'h01, 0, 1, 0);
        cyc("pr_e",     0, 0, 0, 1, 0, 2'd1, 8'h00, 8'h00, 0, 1, 0);
        cyc("pr_f",     0, 0, 0, 1, 0, 2'd1, 8'h00, 8'h03, 1, 1, 1);
        // One-shot: stops after reload, restarted by LD, re-armed by mode change
        cyc("os_ldr",   0, 0, 1, 0, 0, 2'd2, 8'h05, 8'h03, 0, 1, 0);
        cyc("os_ld",    0, 1, 0, 1, 0, 2'd2, 8'h02, 8'h02, 0, 1, 0);
        cyc("os_a",     0, 0, 0, 1, 0, 2'd2, 8'h00, 8'h01, 0, 1, 0);
        cyc("os_b",     0, 0, 0, 1, 0, 2'd2, 8'h00, 8'h00, 0, 1, 0);
        cyc("os_c",     0, 0, 0, 1, 0, 2'd2, 8'h00, 8'h05, 1, 0, 1);
        cyc("os_h1",    0, 0, 0, 1, 0, 2'd2, 8'h00, 8'h05, 0, 0, 0);
        cyc("os_h2",    0, 0, 0, 1, 1, 2'd2, 8'h00, 8'h05, 0, 0, 0);
        cyc("os_rld",   0, 1, 0, 1, 0, 2'd2, 8'h01, 8'h01, 0, 1, 0);
        cyc("os_r1",    0, 0, 0, 1, 0, 2'd2, 8'h00, 8'h00, 0, 1, 0);
        cyc("os_r2",    0, 0, 0, 1, 0, 2'd2, 8'h00, 8'h05, 1, 0, 1);
        cyc("os_m0",    0, 0, 0, 1, 0, 2'd0, 8'h00, 8'h05, 0, 1, 0);
        cyc("os_m1",    0, 0, 0, 1, 0, 2'd0, 8'h00, 8'h04, 0, 1, 0);
        // Load coincident with terminal value suppresses the wrap
        cyc("ldtv_a",   0, 1, 0, 0, 1, 2'd0, 8'hFF, 8'hFF, 0, 1, 0);
        cyc("ldtv_b",   0, 1, 0, 1, 1, 2'd0, 8'h10, 8'h10, 0, 1, 0);
        cyc("ldtv_c",   0, 0, 0, 1, 1, 2'd0, 8'h00, 8'h11, 0, 1, 0);
        // Hold mode: no counting, but LD/LDR still act
        cyc("hold_a",   0, 0, 0, 1, 1, 2'd3, 8'h00, 8'h11, 0, 1, 0);
        cyc("hold_ldr", 0, 0, 1, 1, 1, 2'd3, 8'h07, 8'h11, 0, 1, 0);
        cyc("hold_ld",  0, 1, 0, 1, 1, 2'd3, 8'hFF, 8'hFF, 0, 1, 0);
        cyc("hold_b",   0, 0, 0, 1, 1, 2'd3, 8'h00, 8'hFF, 0, 1, 0);
        cyc("hold_rl",  0, 0, 0, 1, 1, 2'd1, 8'h00, 8'h07, 1, 1, 1);
        // Reset in the middle of a one-shot, then count straight after reset
        cyc("rm_ld",    0, 1, 0, 1, 0, 2'd2, 8'h01, 8'h01, 0, 1, 0);
        cyc("rm_a",     0, 0, 0, 1, 0, 2'd2, 8'h00, 8'h00, 0, 1, 0);
        cyc("rm_rst",   1, 0, 0, 1, 0, 2'd2, 8'h00, 8'h00, 0, 1, 1);
        cyc("rm_rld",   0, 0, 0, 1, 0, 2'd2, 8'h00, 8'h00, 1, 0, 1);
        bus8.ENAB = 1'b0;
        @(posedge CK);
        #2;
        check("sb_empty", sb.size(), 0);

        // Cascade: load lower=F, upper=0, then count
        rst_c = 1'b0;
        lo_if.LD = 1'b1; lo_if.D = 4'hF;
        hi_if.LD = 1'b1; hi_if.D = 4'h0;
        @(posedge CK); #2;
        cas_check("cas_ld", 4'hF, 4'h0, 1'b0, 1'b1);
        lo_if.LD = 1'b0; hi_if.LD = 1'b0; lo_if.ENAB = 1'b1;
        #1;
        check("cas_co", {31'd0, lo_if.CO}, 1);
        @(posedge CK); #2;
        cas_check("cas_1", 4'h0, 4'h1, 1'b1, 1'b1);
        @(posedge CK); #2;
        cas_check("cas_2", 4'h1, 4'h1, 1'b0, 1'b1);
        rst_c = 1'b1;
        @(posedge CK); #2;
        cas_check("cas_rst", 4'h0, 4'h0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
